ex_multicycle_ctrl: RTL and testbench
=====================================

Name: ex_multicycle_ctrl

Overview:
- Sits between the ID/EX pipeline register and the alu. It is the consumer side of the ALU's multi-cycle latency contract.
- Accepts one instruction per issue and looks up its fixed latency. Holds the operands and op stable at the ALU for the whole latency, stalls upstream, then captures alu_res exactly once.
- Emits a single-cycle result pulse with writeback tags to the MEM stage.
- Replaces per-op bubble counting with one owner of the latency timing.

Parameters:
- CNT_W, 6, width of latency counter; must hold MAX_LAT.
- MAX_LAT, 36, largest entry in the latency table (F_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill in-flight instruction (branch mispredict/trap)
- in_valid  in  1  EX-stage instruction present
- in_alu_op  in  alu_op_t  operation
- in_left  in  32  left operand
- in_right  in  32  right operand
- in_rd  in  5  destination register
- in_reg_write  in  1  writeback enable
- stall  out  1  hold IF/ID/EX upstream registers (combinational)
- alu_op  out  alu_op_t  op driven to alu
- alu_left  out  32  operand to alu
- alu_right  out  32  operand to alu
- alu_res  in  32  alu result
- out_valid  out  1  result pulse, registered
- out_res  out  32  captured result, registered
- out_rd  out  5  registered
- out_reg_write  out  1  registered; 0 whenever out_valid=0

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous, active-high.
- Reset values: state IDLE, cnt 0, out_valid 0, out_res 0, out_rd 0, out_reg_write 0. stall is 0 while rst=1.
- Latency table L(op):
  - 2: F_ADD, F_SUB, F_FLOAT_INT
  - 6: MUL, MULH, F_MUL
  - 26: F_SQRT
  - 32: DIV, DIVU, REM, REMU, F_INT_FLOAT
  - 36: F_DIV
  - 0: all other ops, including unknown encodings
- alu_* outputs: driven from in_* in IDLE; driven from latched regs in BUSY.
- FSM IDLE, in_valid=1 issued at cycle T, L=0:
  - stall=0.
  - Capture alu_res at end of T; out_valid=1 in T+1.
- FSM IDLE, in_valid=1, L>0:
  - stall=1 in T.
  - Latch op, operands, rd, reg_write; cnt<=L-1; go BUSY.
- FSM BUSY:
  - stall = (cnt!=0); cnt decrements each cycle.
  - At cnt==0 (cycle T+L): stall=0, capture alu_res and tags, go IDLE. out_valid=1 in T+L+1.
  - Net effect: stall high for exactly L cycles (T..T+L-1); the result appears at T+L+1 for every op.
- in_valid is ignored in BUSY. The upstream still presents the same instruction in T+L; it must not be reissued.
- out_valid is a one-cycle pulse; otherwise 0. out_res and out_rd hold their last values.
- flush:
  - Takes priority over issue and completion. State returns to IDLE, cnt 0.
  - stall=0 in the flush cycle; no out_valid is produced for the killed op.
  - flush in IDLE with in_valid: nothing accepted. A result pulse already scheduled for the flush cycle itself is still visible.
- rst mid-BUSY: same as flush plus all outputs are reset.
- No back-pressure from downstream; MEM always accepts.

Decomposition:
- common_pkg:
  - ex_state_t enum {EX_IDLE, EX_BUSY}.
  - Function alu_latency(alu_op_t) returning logic [5:0].
  - Latency constants LAT_FADD=2, LAT_MUL=6, LAT_SQRT=26, LAT_DIV=32, LAT_FDIV=36.
- No sub-module; the counter and FSM are small enough to stay inline.

Test Plan:
- ADD, 5+7, rd=3 at T: stall never asserted; out_valid at T+1 with out_res=12, out_rd=3, out_reg_write=1.
- DIVU 100/7, in_valid held through stall: stall=1 for T..T+31; single out_valid at T+33 with out_res=14; no second result in T+34..T+40.
- F_ADD 0x3F800000+0x40000000: stall T..T+1; out_res=0x40400000 at T+3. Immediately after, MUL 6*7 at T+3: out_res=42 at T+10.
- DIV issued, flush asserted when cnt=10: stall=0 in the flush cycle; no out_valid for 40 cycles. The next ADD 1+1 completes normally with out_res=2.
- F_DIV issued, rst pulsed at T+5: outputs go to reset values at T+6; no out_valid; FSM accepts a new op at T+6.
- Unknown op encoding: treated as L=0; out_valid at T+1 with whatever alu_res shows, stall never 1.

Source files
------------

// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared types for the EX stage: the ALU operation encoding, the EX controller
// state type and the fixed per-operation ALU latency table.
// Unused encodings of alu_op_t (23..31) are legal on the wire and behave as
// single-cycle operations.
// -----------------------------------------------------------------------------
package common_pkg;

    typedef enum logic [4:0] {
        ADD         = 5'd0,
        SUB         = 5'd1,
        SLL         = 5'd2,
        SLT         = 5'd3,
        SLTU        = 5'd4,
        LOGIC_XOR   = 5'd5,
        SRL         = 5'd6,
        SRA         = 5'd7,
        LOGIC_OR    = 5'd8,
        LOGIC_AND   = 5'd9,
        MUL         = 5'd10,
        MULH        = 5'd11,
        DIV         = 5'd12,
        DIVU        = 5'd13,
        REM         = 5'd14,
        REMU        = 5'd15,
        F_ADD       = 5'd16,
        F_SUB       = 5'd17,
        F_MUL       = 5'd18,
        F_DIV       = 5'd19,
        F_SQRT      = 5'd20,
        F_FLOAT_INT = 5'd21,
        F_INT_FLOAT = 5'd22
    } alu_op_t;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_BUSY = 1'b1
    } ex_state_t;

    localparam logic [5:0] LAT_FADD = 6'd2;
    localparam logic [5:0] LAT_MUL  = 6'd6;
    localparam logic [5:0] LAT_SQRT = 6'd26;
    localparam logic [5:0] LAT_DIV  = 6'd32;
    localparam logic [5:0] LAT_FDIV = 6'd36;

    // Number of cycles the ALU needs its inputs held stable before alu_res
    // is valid. Zero means the result is valid in the same cycle.
    function automatic logic [5:0] alu_latency(input alu_op_t op);
        logic [5:0] lat;
        case (op)
            F_ADD, F_SUB, F_FLOAT_INT:       lat = LAT_FADD;
            MUL, MULH, F_MUL:                lat = LAT_MUL;
            F_SQRT:                          lat = LAT_SQRT;
            DIV, DIVU, REM, REMU,
            F_INT_FLOAT:                     lat = LAT_DIV;
            F_DIV:                           lat = LAT_FDIV;
            default:                         lat = 6'd0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/ex_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// ex_multicycle_ctrl
// Owns the ALU latency timing for the EX stage. An instruction with a nonzero
// latency L is latched at issue, its op/operands are held at the ALU for L
// cycles while upstream is stalled, and alu_res is captured exactly once. The
// result leaves as a one-cycle registered pulse with its writeback tags.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           kill the in-flight instruction (no result is produced)
//   in_valid        instruction present at EX
//   in_alu_op       operation
//   in_left/right   operands
//   in_rd           destination register
//   in_reg_write    writeback enable
//   stall           hold upstream registers (combinational)
//   alu_op/left/right  inputs presented to the ALU
//   alu_res         ALU result
//   out_valid       one-cycle result pulse
//   out_res/out_rd  captured result and destination, held between pulses
//   out_reg_write   writeback enable, 0 whenever out_valid is 0
// -----------------------------------------------------------------------------
module ex_multicycle_ctrl
    import common_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int MAX_LAT = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  alu_op_t     in_alu_op,
    input  logic [31:0] in_left,
    input  logic [31:0] in_right,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        stall,
    output alu_op_t     alu_op,
    output logic [31:0] alu_left,
    output logic [31:0] alu_right,
    input  logic [31:0] alu_res,
    output logic        out_valid,
    output logic [31:0] out_res,
    output logic [4:0]  out_rd,
    output logic        out_reg_write
);

    if (MAX_LAT >= (1 << CNT_W)) begin : g_cnt_width_check
        $error("CNT_W too narrow for MAX_LAT");
    end

    ex_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [5:0]         lat;
    logic               busy;
    logic               issue_multi;

    // Instruction latched for the duration of a multi-cycle operation
    alu_op_t            op_q;
    logic [31:0]        left_q;
    logic [31:0]        right_q;
    logic [4:0]         rd_q;
    logic               reg_write_q;

    assign lat         = alu_latency(in_alu_op);
    assign busy        = (state == EX_BUSY);
    assign issue_multi = !rst && !flush && !busy && in_valid && (lat != 6'd0);

    // While busy the upstream keeps presenting the same instruction, but the
    // ALU is fed from the latched copy so the hold never depends on upstream.
    assign alu_op    = busy ? op_q    : in_alu_op;
    assign alu_left  = busy ? left_q  : in_left;
    assign alu_right = busy ? right_q : in_right;

    // NOTE: every output of a combinational block gets a default first, so no
    //       path through the case leaves it unassigned and no latch appears.
    always_comb begin
        stall = 1'b0;
        if (!rst && !flush) begin
            case (state)
                EX_IDLE: stall = in_valid && (lat != 6'd0);
                EX_BUSY: stall = (cnt != '0);
                default: stall = 1'b0;
            endcase
        end
    end

    // NOTE: pure datapath holding registers carry no reset; they are only
    //       observed while the FSM is BUSY, which always follows a load.
    always_ff @(posedge clk) begin
        if (issue_multi) begin
            op_q        <= in_alu_op;
            left_q      <= in_left;
            right_q     <= in_right;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EX_IDLE;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_res       <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else begin
            // Result is a single-cycle pulse; data and rd hold their value.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            if (flush) begin
                state <= EX_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    EX_IDLE: begin
                        if (in_valid) begin
                            if (lat == 6'd0) begin
                                out_valid     <= 1'b1;
                                out_res       <= alu_res;
                                out_rd        <= in_rd;
                                out_reg_write <= in_reg_write;
                            end else begin
                                state <= EX_BUSY;
                                // The issue cycle itself is the first of L stall cycles.
                                cnt   <= CNT_W'(lat - 6'd1);
                            end
                        end
                    end
                    EX_BUSY: begin
                        if (cnt == '0) begin
                            out_valid     <= 1'b1;
                            out_res       <= alu_res;
                            out_rd        <= rd_q;
                            out_reg_write <= reg_write_q;
                            state         <= EX_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= EX_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ex_multicycle_ctrl
// Bench for ex_multicycle_ctrl. A stand-in ALU returns a poison value until
// its inputs have been held stable for the operation's latency, so a result
// is correct only if the controller honoured the hold. Every issue predicts
// its stall length and result cycle (T+L+1); a monitor matches each out_valid
// pulse against the predictions and flags any pulse nobody predicted.
// -----------------------------------------------------------------------------
module tb_ex_multicycle_ctrl;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    alu_op_t     in_alu_op;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        stall;
    alu_op_t     alu_op;
    logic [31:0] alu_left;
    logic [31:0] alu_right;
    logic [31:0] alu_res;
    logic        out_valid;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    ex_multicycle_ctrl #(.CNT_W(6), .MAX_LAT(36)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_alu_op(in_alu_op), .in_left(in_left), .in_right(in_right),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .stall(stall),
        .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
        .alu_res(alu_res), .out_valid(out_valid), .out_res(out_res),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference: latency table and ALU function -------------
    function automatic int lat_of(input alu_op_t op);
        if (op inside {F_ADD, F_SUB, F_FLOAT_INT})          return 2;
        if (op inside {MUL, MULH, F_MUL})                   return 6;
        if (op == F_SQRT)                                   return 26;
        if (op inside {DIV, DIVU, REM, REMU, F_INT_FLOAT})  return 32;
        if (op == F_DIV)                                    return 36;
        return 0;
    endfunction

    function automatic real sp_to_real(input logic [31:0] b);
        logic [63:0] d;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real x);
        logic [63:0] d;
        d = $realtobits(x);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] alu_fn(input alu_op_t op, input logic [31:0] l, input logic [31:0] r);
        logic signed [63:0] p;
        logic [31:0] ul, ur, q, rm;
        ul = l[31] ? -l : l;
        ur = r[31] ? -r : r;
        q  = (ur != 0) ? ul / ur : 32'd0;
        rm = (ur != 0) ? ul % ur : 32'd0;
        case (op)
            ADD:         return l + r;
            SUB:         return l - r;
            SLL:         return l << r[4:0];
            SLT:         return {31'd0, $signed(l) < $signed(r)};
            SLTU:        return {31'd0, l < r};
            LOGIC_XOR:   return l ^ r;
            SRL:         return l >> r[4:0];
            SRA:         return $signed(l) >>> r[4:0];
            LOGIC_OR:    return l | r;
            LOGIC_AND:   return l & r;
            MUL:         return l * r;
            MULH: begin
                p = $signed({{32{l[31]}}, l}) * $signed({{32{r[31]}}, r});
                return p[63:32];
            end
            DIV:         return (r == 0) ? 32'hFFFF_FFFF : ((l[31] ^ r[31]) ? -q : q);
            DIVU:        return (r == 0) ? 32'hFFFF_FFFF : l / r;
            REM:         return (r == 0) ? l : (l[31] ? -rm : rm);
            REMU:        return (r == 0) ? l : l % r;
            F_ADD:       return real_to_sp(sp_to_real(l) + sp_to_real(r));
            F_SUB:       return real_to_sp(sp_to_real(l) - sp_to_real(r));
            F_MUL:       return l ^ {r[15:0], r[31:16]};
            F_DIV:       return l - {r[7:0], r[31:8]};
            F_SQRT:      return ~l;
            F_FLOAT_INT: return {l[15:0], r[15:0]};
            F_INT_FLOAT: return l + 32'h1357_9BDF;
            default:     return 32'hC0DE_0000;
        endcase
    endfunction

    // ---------------- stand-in ALU honouring the latency contract -----------
    alu_op_t     prev_op;
    logic [31:0] prev_l, prev_r;
    int          run_len = 0;
    int          stable_now;

    always @(posedge clk) begin
        if (alu_op == prev_op && alu_left == prev_l && alu_right == prev_r)
            run_len <= run_len + 1;
        else
            run_len <= 1;
        prev_op <= alu_op;
        prev_l  <= alu_left;
        prev_r  <= alu_right;
    end

    always_comb begin
        stable_now = 0;
        if (alu_op == prev_op && alu_left == prev_l && alu_right == prev_r)
            stable_now = run_len;
        alu_res = (stable_now >= lat_of(alu_op)) ? alu_fn(alu_op, alu_left, alu_right)
                                                 : 32'hDEAD_BEEF;
    end

    // ---------------- scoreboard and output monitor -------------------------
    typedef struct {
        int          at;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                pulses++;
                if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_res", out_res, e.res);
                    check("out_rd", 32'(out_rd), 32'(e.rd));
                    check("out_reg_write", 32'(out_reg_write), 32'(e.rw));
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got out_valid=1 expected 0 (cycle %0d)", cyc);
                end
            end else begin
                check("reg_write_when_idle", 32'(out_reg_write), 32'd0);
            end
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_pulse: got none expected result at cycle %0d (now %0d)",
                         exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver -------------------------------------------------
    // Present an instruction (caller is in the first half of a cycle), hold it
    // while stall is high, check the stall length and schedule the result.
    task automatic issue(input alu_op_t op, input logic [31:0] l, input logic [31:0] r,
                         input logic [4:0] rd, input logic rw, input logic [31:0] res,
                         input int lat, input string name);
        int   t0;
        int   n;
        exp_t e;
        n            = 0;
        in_valid     = 1'b1;
        in_alu_op    = op;
        in_left      = l;
        in_right     = r;
        in_rd        = rd;
        in_reg_write = rw;
        t0           = cyc;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk);
            #1;
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(lat));
        e.at  = t0 + lat + 1;
        e.res = res;
        e.rd  = rd;
        e.rw  = rw;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        alu_op_t     op;
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] res;
        int          lat;
        int          gap;
        string       name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;

        vecs[0]  = '{ADD,    32'd5,         32'd7,         5'd3,  1'b1, 32'd12,        0,  0, "add"};
        vecs[1]  = '{DIVU,   32'd100,       32'd7,         5'd4,  1'b1, 32'd14,        32, 8, "divu"};
        vecs[2]  = '{F_ADD,  32'h3F80_0000, 32'h4000_0000, 5'd5,  1'b1, 32'h4040_0000, 2,  0, "fadd"};
        vecs[3]  = '{MUL,    32'd6,         32'd7,         5'd6,  1'b1, 32'd42,        6,  0, "mul"};
        vecs[4]  = '{SUB,    32'd10,        32'd3,         5'd7,  1'b0, 32'd7,         0,  0, "sub_nowb"};
        vecs[5]  = '{REMU,   32'd100,       32'd7,         5'd8,  1'b1, 32'd2,         32, 0, "remu"};
        vecs[6]  = '{DIV,    32'hFFFF_FF9C, 32'd7,         5'd9,  1'b1, 32'hFFFF_FFF2, 32, 0, "div_neg"};
        vecs[7]  = '{REM,    32'hFFFF_FF9C, 32'd7,         5'd10, 1'b1, 32'hFFFF_FFFE, 32, 1, "rem_neg"};
        vecs[8]  = '{MULH,   32'h8000_0000, 32'd2,         5'd11, 1'b1, 32'hFFFF_FFFF, 6,  0, "mulh"};
        vecs[9]  = '{alu_op_t'(5'd31), 32'd1, 32'd2,       5'd12, 1'b1, 32'hC0DE_0000, 0,  0, "unknown_op"};
        vecs[10] = '{DIV,    32'd5,         32'd0,         5'd13, 1'b1, 32'hFFFF_FFFF, 32, 0, "div_zero"};
        vecs[11] = '{F_SQRT, 32'h1234_5678, 32'd0,         5'd14, 1'b1, 32'hEDCB_A987, 26, 0, "fsqrt"};
        vecs[12] = '{F_DIV,  32'h10,        32'h100,       5'd15, 1'b1, 32'h0000_000F, 36, 2, "fdiv_max"};
        vecs[13] = '{SLT,    32'hFFFF_FFFF, 32'd1,         5'd16, 1'b1, 32'd1,         0,  0, "slt"};

        // Reset: outputs cleared and stall suppressed even with a long op presented.
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_alu_op = DIV; in_left = 32'd9; in_right = 32'd3;
        in_rd = 5'd1; in_reg_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_res", out_res, 32'd0);
        check("reset_out_rd", 32'(out_rd), 32'd0);
        check("reset_out_reg_write", 32'(out_reg_write), 32'd0);
        rst = 1'b0; in_valid = 1'b0; mon_en = 1'b1;
        idle(2);

        // Directed table, back-to-back where gap is 0.
        for (int i = 0; i < $size(vecs); i++) begin
            issue(vecs[i].op, vecs[i].l, vecs[i].r, vecs[i].rd, vecs[i].rw,
                  vecs[i].res, vecs[i].lat, vecs[i].name);
            idle(vecs[i].gap);
        end
        idle(4);

        // Flush with cnt=10 during a DIV: no stall in the flush cycle, no result.
        in_valid = 1'b1; in_alu_op = DIV; in_left = 32'd50; in_right = 32'd5;
        in_rd = 5'd20; in_reg_write = 1'b1;
        n = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (stall) n++;
            @(posedge clk);
            #1;
        end
        check("pre_flush_stall_cycles", 32'(n), 32'd22);
        flush = 1'b1;
        @(negedge clk);
        check("stall_in_flush_cycle", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        p0 = pulses;
        idle(40);
        check("no_pulse_after_flush", 32'(pulses - p0), 32'd0);
        issue(ADD, 32'd1, 32'd1, 5'd21, 1'b1, 32'd2, 0, "add_after_flush");

        // Flush in IDLE: the already-scheduled pulse stays visible, MUL is dropped.
        issue(ADD, 32'd9, 32'd9, 5'd22, 1'b1, 32'd18, 0, "add_before_idle_flush");
        flush = 1'b1; in_valid = 1'b1; in_alu_op = MUL; in_left = 32'd2; in_right = 32'd3;
        @(negedge clk);
        check("stall_idle_flush", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        issue(ADD, 32'd1, 32'd2, 5'd23, 1'b1, 32'd3, 0, "add_after_idle_flush");
        idle(8);

        // Reset pulsed at T+5 of an F_DIV.
        in_valid = 1'b1; in_alu_op = F_DIV; in_left = 32'h40; in_right = 32'h200;
        in_rd = 5'd24; in_reg_write = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("stall_during_rst", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        #2;
        check("rst_mid_busy_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy_out_res", out_res, 32'd0);
        check("rst_mid_busy_out_rd", 32'(out_rd), 32'd0);
        check("rst_mid_busy_out_reg_write", 32'(out_reg_write), 32'd0);
        issue(ADD, 32'd3, 32'd4, 5'd25, 1'b1, 32'd7, 0, "add_after_rst");
        idle(3);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            alu_op_t     op;
            logic [31:0] l, r;
            logic [4:0]  rd;
            logic        rw;
            op = alu_op_t'(5'($urandom_range(0, 31)));
            l  = $urandom;
            r  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            rd = 5'($urandom_range(0, 31));
            rw = 1'($urandom_range(0, 1));
            issue(op, l, r, rd, rw, alu_fn(op, l, r), lat_of(op), "rand");
            idle($urandom_range(0, 2));
        end

        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_pending_results", 32'(exp_q.size()), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
